sram_ctrl: RTL and testbench

//  Parametrised asynchronous external SRAM controller between the core LSU bus and the off-chip SRAM.

---
 rtl/sram_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Asynchronous external SRAM controller: splits byte/half/word LSU requests into MEM_DW-wide beats.
// Optional macro SRAM_CTRL_ERR_EN reports misaligned half/word accesses on err_o instead of aligning down.
module sram_ctrl #(
    parameter int ADDR_W  = 19,
    parameter int MEM_DW  = 8,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [1:0]        hb_i,
    input  logic              uload_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    inout  wire  [MEM_DW-1:0] mem_dq_io,
    output logic              mem_ce_n_o,
    output logic              mem_oe_n_o,
    output logic              mem_we_n_o
);
    localparam int LANES    = MEM_DW / 8;
    localparam int SHIFT    = $clog2(LANES);
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_STRB = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              we_q, we_d;
    logic              uload_q, uload_d;
    logic [1:0]        hb_q, hb_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        beat_q, beat_d;
    logic [1:0]        last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]  size_m1;
    logic [31:0] addr_al;
    logic [31:0] base_full;
    logic [31:0] rd_beat;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;
    logic        misaligned;
    logic        last_wait;
    logic        dq_oe;
    logic        unused_base;

    // Misaligned half/word requests are aligned down to their natural size before splitting.
    assign size_m1     = hb_i[1] ? 2'd3 : {1'b0, hb_i[0]};
    assign addr_al     = addr_i & ~{30'd0, size_m1};
    assign base_full   = addr_al >> SHIFT;
    assign unused_base = ^base_full;

`ifdef SRAM_CTRL_ERR_EN
    assign misaligned = (hb_i == 2'b01 && addr_i[0]) || (hb_i[1] && addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign last_wait = we_q ? (cnt_q == CNT_W'(WR_WAIT - 1)) : (cnt_q == CNT_W'(RD_WAIT - 1));

    // Read beats land in their little-endian lane slot; sub-width reads then shift down by lane.
    assign rd_beat  = 32'(mem_dq_io) << (int'(beat_q) * MEM_DW);
    assign rd_shift = (rbuf_q | rd_beat) >> {lane_q, 3'b000};

    always_comb begin
        case (hb_q)
            2'b00:   rd_ext = uload_q ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = uload_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no branch of the case can infer a latch.
        state_d = state_q;
        we_d    = we_q;
        uload_d = uload_q;
        hb_d    = hb_q;
        lane_d  = lane_q;
        beat_d  = beat_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    uload_d = uload_i;
                    hb_d    = hb_i;
                    lane_d  = addr_al[1:0] & 2'(LANES - 1);
                    last_d  = size_m1 >> SHIFT;
                    wdata_d = wdata_i;
                    maddr_d = base_full[ADDR_W-1:0];
                    beat_d  = 2'd0;
                    rbuf_d  = 32'd0;
                    err_d   = misaligned;
                    state_d = misaligned ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d   = '0;
                state_d = S_STRB;
            end
            S_STRB: begin
                if (!last_wait) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (we_q) begin
                    state_d = S_HOLD;
                end else begin
                    rbuf_d = rbuf_q | rd_beat;
                    if (beat_q == last_q) begin
                        rdata_d = rd_ext;
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        maddr_d = maddr_q + 1'b1;
                        state_d = S_ADDR;
                    end
                end
            end
            S_HOLD: begin
                if (beat_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    beat_d  = beat_q + 2'd1;
                    maddr_d = maddr_q + 1'b1;
                    wdata_d = wdata_q >> MEM_DW;
                    state_d = S_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking so every flop samples the pre-edge _d values together.
        if (rst_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            uload_q <= 1'b0;
            hb_q    <= 2'b00;
            lane_q  <= 2'd0;
            beat_q  <= 2'd0;
            last_q  <= 2'd0;
            cnt_q   <= '0;
            maddr_q <= '0;
            wdata_q <= 32'd0;
            rbuf_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uload_q <= uload_d;
            hb_q    <= hb_d;
            lane_q  <= lane_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // dq is released in ADDR so the SRAM and controller never overlap across a turnaround.
    assign dq_oe      = (state_q == S_STRB && we_q) || state_q == S_HOLD;
    assign mem_dq_io  = dq_oe ? wdata_q[MEM_DW-1:0] : {MEM_DW{1'bz}};
    assign mem_ce_n_o = !(state_q == S_ADDR || state_q == S_STRB || state_q == S_HOLD);
    assign mem_oe_n_o = !(state_q == S_STRB && !we_q);
    assign mem_we_n_o = !(state_q == S_STRB && we_q);
    assign mem_addr_o = maddr_q;
    assign done_o     = state_q == S_DONE;
    assign err_o      = done_o && err_q;
    assign stall_o    = req_i && !done_o;
    assign rdata_o    = rdata_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl (MEM_DW=8, RD_WAIT=WR_WAIT=2) with a behavioural async SRAM.
// Covers both builds: SRAM_CTRL_ERR_EN selects the expected outcome of the misaligned-half vector.
module tb_sram_ctrl;
    localparam int ADDR_W  = 19;
    localparam int MEM_DW  = 8;
    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_i;
    logic              we_i;
    logic [31:0]       addr_i;
    logic [31:0]       wdata_i;
    logic [1:0]        hb_i;
    logic              uload_i;
    logic [31:0]       rdata_o;
    logic              done_o;
    logic              stall_o;
    logic              err_o;
    logic [ADDR_W-1:0] mem_addr_o;
    wire  [MEM_DW-1:0] mem_dq_io;
    logic              mem_ce_n_o;
    logic              mem_oe_n_o;
    logic              mem_we_n_o;

    sram_ctrl #(
        .ADDR_W (ADDR_W),
        .MEM_DW (MEM_DW),
        .RD_WAIT(RD_WAIT),
        .WR_WAIT(WR_WAIT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .hb_i      (hb_i),
        .uload_i   (uload_i),
        .rdata_o   (rdata_o),
        .done_o    (done_o),
        .stall_o   (stall_o),
        .err_o     (err_o),
        .mem_addr_o(mem_addr_o),
        .mem_dq_io (mem_dq_io),
        .mem_ce_n_o(mem_ce_n_o),
        .mem_oe_n_o(mem_oe_n_o),
        .mem_we_n_o(mem_we_n_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural SRAM: drives dq while CE#/OE# are low, stores dq while CE#/WE# are low.
    logic [7:0]  sram [0:4095];
    logic [11:0] sram_idx;
    logic        sram_drive;
    logic        pk_en = 1'b0;
    logic [11:0] pk_addr;
    logic [7:0]  pk_data;
    wire         unused_hi = ^mem_addr_o[ADDR_W-1:12];

    assign sram_idx   = mem_addr_o[11:0];
    assign sram_drive = !mem_ce_n_o && !mem_oe_n_o && mem_we_n_o;
    assign mem_dq_io  = sram_drive ? sram[sram_idx] : 8'bz;

    always @(negedge clk_i) begin
        if (pk_en) sram[pk_addr] = pk_data;
        else if (!mem_ce_n_o && !mem_we_n_o) sram[sram_idx] = mem_dq_io;
    end

    typedef struct {
        int unsigned due;
        logic        is_rd;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    int          both_low = 0;
    int          ce_low_cnt = 0;
    int          we_pulses = 0;
    logic        prev_we_n = 1'b1;
    logic [31:0] last_rd = 32'd0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done_o pulse; also tracks strobe activity.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (!mem_oe_n_o && !mem_we_n_o) both_low++;
            if (!mem_ce_n_o) ce_low_cnt++;
            if (!mem_we_n_o && prev_we_n) we_pulses++;
            prev_we_n = mem_we_n_o;
            if (done_o) begin
                check("done_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("done_cycle", 32'(cyc), 32'(mon_e.due));
                    check("err_o", 32'(err_o), 32'(mon_e.err));
                    if (mon_e.is_rd) check("rdata_o", rdata_o, mon_e.rdata);
                end
            end
        end
    end

    function automatic int lat_of(input logic we, input logic [1:0] hb);
        int beats;
        beats = (hb == 2'b00) ? 1 : (hb == 2'b01) ? 2 : 4;
        return we ? beats * (2 + WR_WAIT) + 1 : beats * (1 + RD_WAIT) + 1;
    endfunction

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pk_en   = 1'b1;
        pk_addr = a;
        pk_data = d;
        @(negedge clk_i);
        #1;
        pk_en = 1'b0;
    endtask

    // Called at a negedge; acc_dly is the number of edges until the DUT accepts.
    task automatic start(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] hb, input logic uload, input logic [31:0] exp_rd,
                         input logic exp_err, input int acc_dly);
        exp_t e;
        int   lat;
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        hb_i    = hb;
        uload_i = uload;
        lat     = exp_err ? 1 : lat_of(we, hb);
        e.due   = cyc + acc_dly + lat - 1;
        e.is_rd = !we || exp_err;
        e.rdata = exp_err ? last_rd : exp_rd;
        e.err   = exp_err;
        if (!we && !exp_err) last_rd = exp_rd;
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit keep);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!done_o && n < 200);
        if (!done_o) check("done_timeout", 32'(done_o), 32'd1);
        if (!keep) req_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          pulses0;
        int          ce0;
        int unsigned c0;
        rst_i   = 1'b1;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = 32'd0;
        wdata_i = 32'd0;
        hb_i    = 2'b00;
        uload_i = 1'b0;
        poke(12'h200, 8'h01);
        poke(12'h201, 8'h80);
        for (int i = 0; i < 4; i++) poke(12'h300 + 12'(i), 8'h11);
        @(negedge clk_i);

        check("rst_ce_n", 32'(mem_ce_n_o), 32'd1);
        check("rst_oe_n", 32'(mem_oe_n_o), 32'd1);
        check("rst_we_n", 32'(mem_we_n_o), 32'd1);
        check("rst_addr", 32'(mem_addr_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Byte write then signed/unsigned readback.
        start(1'b1, 32'h10, 32'h0000_00A5, 2'b00, 1'b0, 32'd0, 1'b0, 1);
        @(negedge clk_i);
        check("stall_busy", 32'(stall_o), 32'd1);
        wait_done(0);
        @(negedge clk_i);
        start(1'b0, 32'h10, 32'd0, 2'b00, 1'b0, 32'hFFFF_FFA5, 1'b0, 1);
        wait_done(0);
        @(negedge clk_i);
        start(1'b0, 32'h10, 32'd0, 2'b00, 1'b1, 32'h0000_00A5, 1'b0, 1);
        wait_done(0);
        check("sram_0x10", 32'(sram[12'h010]), 32'h0000_00A5);

        // Word write: four WE# pulses, little-endian byte order, readback.
        @(negedge clk_i);
        pulses0 = we_pulses;
        start(1'b1, 32'h100, 32'h1234_5678, 2'b10, 1'b0, 32'd0, 1'b0, 1);
        wait_done(0);
        check("we_pulses", 32'(we_pulses - pulses0), 32'd4);
        check("sram_0x100", 32'(sram[12'h100]), 32'h78);
        check("sram_0x101", 32'(sram[12'h101]), 32'h56);
        check("sram_0x102", 32'(sram[12'h102]), 32'h34);
        check("sram_0x103", 32'(sram[12'h103]), 32'h12);
        @(negedge clk_i);
        start(1'b0, 32'h100, 32'd0, 2'b10, 1'b0, 32'h1234_5678, 1'b0, 1);
        wait_done(0);

        // Half reads with sign and zero extension.
        @(negedge clk_i);
        start(1'b0, 32'h200, 32'd0, 2'b01, 1'b0, 32'hFFFF_8001, 1'b0, 1);
        wait_done(0);
        @(negedge clk_i);
        start(1'b0, 32'h200, 32'd0, 2'b01, 1'b1, 32'h0000_8001, 1'b0, 1);
        wait_done(0);

        // Read followed by a write with req_i held through DONE.
        @(negedge clk_i);
        start(1'b0, 32'h200, 32'd0, 2'b00, 1'b0, 32'h0000_0001, 1'b0, 1);
        wait_done(1);
        start(1'b1, 32'h20, 32'h0000_005A, 2'b00, 1'b0, 32'd0, 1'b0, 2);
        wait_done(0);
        @(negedge clk_i);
        start(1'b0, 32'h20, 32'd0, 2'b00, 1'b1, 32'h0000_005A, 1'b0, 1);
        wait_done(0);

        // Misaligned half read at 0x101.
        @(negedge clk_i);
        ce0 = ce_low_cnt;
`ifdef SRAM_CTRL_ERR_EN
        start(1'b0, 32'h101, 32'd0, 2'b01, 1'b0, 32'd0, 1'b1, 1);
        wait_done(0);
        check("err_no_ce", 32'(ce_low_cnt - ce0), 32'd0);
`else
        start(1'b0, 32'h101, 32'd0, 2'b01, 1'b0, 32'h0000_5678, 1'b0, 1);
        wait_done(0);
        check("aligned_ce", 32'(ce_low_cnt - ce0), 32'd6);
`endif

        // Reset during the address cycle of beat 2 of a word write.
        @(negedge clk_i);
        c0 = cyc;
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = 32'h300;
        wdata_i = 32'hCAFE_BABE;
        hb_i    = 2'b10;
        uload_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check("beat2_cycle", 32'(cyc - c0), 32'd9);
        check("beat2_addr", 32'(mem_addr_o), 32'h302);
        rst_i   = 1'b1;
        req_i   = 1'b0;
        last_rd = 32'd0;
        @(negedge clk_i);
        check("rst_mid_ce_n", 32'(mem_ce_n_o), 32'd1);
        check("rst_mid_we_n", 32'(mem_we_n_o), 32'd1);
        check("rst_mid_done", 32'(done_o), 32'd0);
        check("rst_mid_addr", 32'(mem_addr_o), 32'd0);
        check("rst_mid_rdata", rdata_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("sram_0x300", 32'(sram[12'h300]), 32'hBE);
        check("sram_0x301", 32'(sram[12'h301]), 32'hBA);
        check("sram_0x302", 32'(sram[12'h302]), 32'h11);
        check("sram_0x303", 32'(sram[12'h303]), 32'h11);

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("oe_we_overlap", 32'(both_low), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
